// File: rtl/slave_port.sv
// rtl/slave_port.sv - serial-bus responder: deserialises address/mode/write data, serialises read data
//
// Purpose:
//   Slave end of the serial link driven by master_port. A frame starts with
//   the first address bit, when the transfer mode is also latched. Address
//   bits and write data arrive LSB first, one bit per cycle with mvalid high.
//   Cycles with mvalid low are gaps. A write issues a one-cycle smemwen
//   strobe. A read issues a one-cycle smemren strobe, waits for rvalid, and
//   then shifts the returned word out LSB first while svalid is high.
//
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   swdata     in   serial write data (address and data bits)
//   smode      in   0 = read, 1 = write; sampled with the first address bit
//   mvalid     in   bit-valid from the decoder, one bit per high cycle
//   srdata     out  serial read data
//   svalid     out  read-data bit valid
//   sready     out  idle and able to accept a new frame
//   smemaddr   out  [ADDR_WIDTH] local memory address
//   smemwdata  out  [DATA_WIDTH] memory write data
//   smemwen    out  one-cycle write strobe
//   smemren    out  one-cycle read strobe
//   smemrdata  in   [DATA_WIDTH] memory read data
//   rvalid     in   smemrdata valid (observed only while waiting for a read)
//
// ADDR_WIDTH and DATA_WIDTH are expected to be at least 2.

module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  output logic                  smemwen,
  output logic                  smemren,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  rvalid
);

  localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(MAX_WIDTH + 1);

  // Address bit 0 is taken in IDLE, so the ADDR phase counts the remaining
  // ADDR_WIDTH-1 bits and its last bit arrives at count ADDR_WIDTH-2.
  localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH - 2);
  localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WRITE = 3'd3,
    S_RREQ  = 3'd4,
    S_RWAIT = 3'd5,
    S_RDATA = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_mode;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    w_phase_change;
  logic                    w_cnt_step;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mvalid) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (mvalid && (r_cnt == ADDR_LAST)) w_next = r_mode ? S_WDATA : S_RREQ;
      end
      S_WDATA: begin
        if (mvalid && (r_cnt == DATA_LAST)) w_next = S_WRITE;
      end
      S_WRITE: w_next = S_IDLE;
      S_RREQ:  w_next = S_RWAIT;
      S_RWAIT: begin
        if (rvalid) w_next = S_RDATA;
      end
      S_RDATA: begin
        if (r_cnt == DATA_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic: every strobe and serial output decodes straight from the
  // state, so an asynchronous reset drops them in the same instant.
  always_comb begin
    sready  = 1'b0;
    svalid  = 1'b0;
    srdata  = 1'b0;
    smemwen = 1'b0;
    smemren = 1'b0;
    case (r_state)
      S_IDLE:  sready  = 1'b1;
      S_WRITE: smemwen = 1'b1;
      S_RREQ:  smemren = 1'b1;
      S_RDATA: begin
        svalid = 1'b1;
        srdata = r_shift[0];
      end
      default: ;
    endcase
  end

  // The bit counter is shared by ADDR, WDATA and RDATA; it restarts whenever
  // the state changes and advances only on cycles that move a bit.
  assign w_phase_change = (w_next != r_state);
  assign w_cnt_step     = (((r_state == S_ADDR) || (r_state == S_WDATA)) && mvalid) ||
                          (r_state == S_RDATA);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_phase_change) begin
      r_cnt <= '0;
    end else if (w_cnt_step) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Mode is captured with address bit 0 only; later smode values are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode <= 1'b0;
    end else if ((r_state == S_IDLE) && mvalid) begin
      r_mode <= smode;
    end
  end

  // Address and write data shift in from the top so that, after the full
  // LSB-first sequence, bit 0 has reached the bottom of the register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr <= '0;
    end else if (((r_state == S_IDLE) || (r_state == S_ADDR)) && mvalid) begin
      r_addr <= {swdata, r_addr[ADDR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdata <= '0;
    end else if ((r_state == S_WDATA) && mvalid) begin
      r_wdata <= {swdata, r_wdata[DATA_WIDTH-1:1]};
    end
  end

  // Read shift register: loaded when memory answers, drained LSB first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= '0;
    end else if ((r_state == S_RWAIT) && rvalid) begin
      r_shift <= smemrdata;
    end else if (r_state == S_RDATA) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign smemaddr  = r_addr;
  assign smemwdata = r_wdata;

endmodule

// File: tb/tb_slave_port.sv
// tb/tb_slave_port.sv - scoreboard testbench for slave_port

module tb_slave_port;

  logic        clk;
  logic        rstn;
  logic        swdata;
  logic        smode;
  logic        mvalid;
  logic        srdata;
  logic        svalid;
  logic        sready;
  logic [11:0] smemaddr;
  logic [7:0]  smemwdata;
  logic        smemwen;
  logic        smemren;
  logic [7:0]  smemrdata;
  logic        mem_rvalid;
  logic        spur_rvalid;
  logic        w_rvalid;

  assign w_rvalid = mem_rvalid | spur_rvalid;

  slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .swdata    (swdata),
    .smode     (smode),
    .mvalid    (mvalid),
    .srdata    (srdata),
    .svalid    (svalid),
    .sready    (sready),
    .smemaddr  (smemaddr),
    .smemwdata (smemwdata),
    .smemwen   (smemwen),
    .smemren   (smemren),
    .smemrdata (smemrdata),
    .rvalid    (w_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  typedef struct {
    logic [11:0] a;
    int          c;
  } rd_t;

  wr_t  exp_wr[$];
  rd_t  exp_rd[$];
  logic exp_bits[$];

  logic [7:0] ref_mem [logic [11:0]];
  logic [7:0] dut_mem [logic [11:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = 1;
  bit rst_test = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor / scoreboard: compare every strobe and serial bit with the queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (smemwen) begin
        if (exp_wr.size() == 0) begin
          check("wen_unexpected", 1, 0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wen_addr", smemaddr, w.a);
          check("wen_data", smemwdata, w.d);
          check("wen_cycle", cyc, w.c);
        end
        dut_mem[smemaddr] = smemwdata;
      end
      if (smemren) begin
        if (exp_rd.size() == 0) begin
          check("ren_unexpected", 1, 0);
        end else begin
          rd_t r;
          r = exp_rd.pop_front();
          check("ren_addr", smemaddr, r.a);
          check("ren_cycle", cyc, r.c);
        end
      end
      if (svalid) begin
        if (exp_bits.size() == 0) check("svalid_unexpected", 1, 0);
        else check("srdata", srdata, exp_bits.pop_front());
      end
    end
  end

  // Memory model: answers smemren after mem_lat cycles and checks the
  // read-out window of exactly 8 svalid cycles followed by idle.
  initial begin
    logic [11:0] a;
    mem_rvalid = 1'b0;
    smemrdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (smemren) begin
        a = smemaddr;
        repeat (mem_lat) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        smemrdata  = dut_mem.exists(a) ? dut_mem[a] : 8'h00;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (!rst_test) check("rd_svalid_window", svalid, 1);
        end
        @(negedge clk);
        if (!rst_test) begin
          check("rd_svalid_end", svalid, 0);
          check("rd_sready_back", sready, 1);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!sready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!sready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_svalid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!svalid && n < 100);
    if (!svalid) check("svalid_timeout", 0, 1);
  endtask

  // Drives one frame; ga_i/gd_i are the bit indices after which ga_n/gd_n
  // gap cycles are inserted (-1 for none). smode is inverted after the first
  // bit to show that only the first sample counts.
  task automatic send_frame(input logic mode, input logic [11:0] a, input logic [7:0] d,
                            input int ga_i, input int ga_n, input int gd_i, input int gd_n);
    int t0;
    int g_a;
    int g_d;
    logic [7:0] rd;
    wait_ready();
    t0  = cyc + 1;
    g_a = (ga_i >= 0) ? ga_n : 0;
    g_d = (gd_i >= 0) ? gd_n : 0;
    if (mode) begin
      exp_wr.push_back('{a, d, t0 + 19 + g_a + g_d});
      ref_mem[a] = d;
    end else begin
      exp_rd.push_back('{a, t0 + 11 + g_a});
      rd = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
      for (int i = 0; i < 8; i++) exp_bits.push_back(rd[i]);
    end
    for (int i = 0; i < 12; i++) begin
      smode  = (i == 0) ? mode : ~mode;
      swdata = a[i];
      mvalid = 1'b1;
      @(posedge clk);
      #1;
      mvalid = 1'b0;
      if (i == 0) check("sready_fall", sready, 0);
      if (i == ga_i) repeat (ga_n) begin @(posedge clk); #1; end
    end
    if (mode) begin
      for (int i = 0; i < 8; i++) begin
        swdata = d[i];
        mvalid = 1'b1;
        @(posedge clk);
        #1;
        mvalid = 1'b0;
        if (i == gd_i) repeat (gd_n) begin @(posedge clk); #1; end
      end
    end
    smode  = 1'b0;
    swdata = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn        = 1'b0;
    swdata      = 1'b0;
    smode       = 1'b0;
    mvalid      = 1'b0;
    spur_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sready", sready, 1);
    check("rst_svalid", svalid, 0);
    check("rst_srdata", srdata, 0);
    check("rst_wen", smemwen, 0);
    check("rst_ren", smemren, 0);
    check("rst_addr", smemaddr, 12'h000);
    check("rst_wdata", smemwdata, 8'h00);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Gapless write
    send_frame(1'b1, 12'h234, 8'hAA, -1, 0, -1, 0);

    // Read with 3-cycle memory latency, memory word 0x5C
    wait_ready();
    ref_mem[12'h234] = 8'h5C;
    dut_mem[12'h234] = 8'h5C;
    mem_lat = 3;
    send_frame(1'b0, 12'h234, 8'h00, -1, 0, -1, 0);
    wait_ready();

    // Gapped write: +2 after address bit 5, +3 after data bit 3
    mem_lat = 1;
    send_frame(1'b1, 12'hFFF, 8'h81, 5, 2, 3, 3);

    // Back-to-back write then read of the same location
    send_frame(1'b1, 12'h001, 8'h3C, -1, 0, -1, 0);
    send_frame(1'b0, 12'h001, 8'h00, -1, 0, -1, 0);
    wait_ready();

    // Reset during RDATA bit 3
    rst_test = 1'b1;
    send_frame(1'b0, 12'h234, 8'h00, -1, 0, -1, 0);
    wait_svalid();
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_svalid", svalid, 0);
    check("abort_sready", sready, 1);
    check("abort_wen", smemwen, 0);
    check("abort_ren", smemren, 0);
    check("abort_addr", smemaddr, 12'h000);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_bits.delete();
    repeat (20) @(posedge clk);
    rst_test = 1'b0;
    #1;

    // Spurious mvalid during RDATA, spurious rvalid in IDLE
    mem_lat = 2;
    send_frame(1'b0, 12'h001, 8'h00, -1, 0, -1, 0);
    wait_svalid();
    mvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      mvalid = ~mvalid;
      swdata = 1'($urandom);
    end
    @(posedge clk);
    #1;
    mvalid = 1'b0;
    wait_ready();
    spur_rvalid = 1'b1;
    @(posedge clk);
    #1;
    spur_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_sready", sready, 1);
      check("spur_svalid", svalid, 0);
    end

    // Normal traffic still works afterwards
    mem_lat = 1;
    send_frame(1'b1, 12'h7E5, 8'h96, -1, 0, -1, 0);
    send_frame(1'b0, 12'h7E5, 8'h00, -1, 0, -1, 0);

    n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_bits.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (12) @(posedge clk);
    check("drain_wr", exp_wr.size(), 0);
    check("drain_rd", exp_rd.size(), 0);
    check("drain_bits", exp_bits.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/slave_port.md
# slave_port

Serial-bus responder for the system bus. It sits behind the address decoder, on the slave end of the serial link driven by `master_port`. It deserialises the device-local address, the mode and any write data into a parallel request for the attached memory or peripheral. For reads it serialises the returned data back to the master with `svalid`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: device-local address width (bus address width minus the decoder's device-address width).
- `DATA_WIDTH`, default 8: data word width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous assertion, active-low.
- `swdata`  in  1  serial write data from the bus (the master's `mwdata`).
- `smode`  in  1  transfer mode, 0 = read, 1 = write; sampled with the first address bit only.
- `mvalid`  in  1  this slave's bit-valid from the decoder; one bit is transferred per cycle in which it is high.
- `srdata`  out  1  serial read data to the bus (the master's `mrdata`).
- `svalid`  out  1  read-data bit valid.
- `sready`  out  1  high when idle and able to accept a new frame.
- `smemaddr`  out  ADDR_WIDTH  local address to memory.
- `smemwdata`  out  DATA_WIDTH  write data to memory.
- `smemwen`  out  1  one-cycle write strobe.
- `smemren`  out  1  one-cycle read strobe.
- `smemrdata`  in  DATA_WIDTH  read data from memory.
- `rvalid`  in  1  `smemrdata` valid.

## Operation
- States: IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA.
- IDLE: `sready` = 1. An edge with `mvalid` = 1 samples address bit 0 and latches `smode`, then moves to ADDR.
- ADDR: address bits arrive LSB first, one per edge with `mvalid` = 1. Cycles with `mvalid` = 0 are gaps: hold state and counter, no timeout.
- After the edge that samples address bit ADDR_WIDTH-1:
  - write goes to WDATA;
  - read goes to RREQ.
- WDATA: DATA_WIDTH data bits, LSB first, with the same gap rule. After the edge that samples the last bit, go to WRITE.
- WRITE: `smemwen` = 1 for exactly one cycle, with `smemaddr` and `smemwdata` stable. Then go to IDLE.
- RREQ: `smemren` = 1 for one cycle with `smemaddr` stable. Then go to RWAIT.
- RWAIT: wait for `rvalid` = 1. On that edge, capture `smemrdata` into the shift register and go to RDATA. `rvalid` is ignored in every other state. There is no timeout.
- RDATA: `svalid` = 1 for exactly DATA_WIDTH consecutive cycles, with `srdata` = the current LSB of the shift register, shifting right each edge. Then go to IDLE.
- `mvalid` is ignored in WRITE, RREQ, RWAIT and RDATA.
- A single bit counter, sized for max(ADDR_WIDTH, DATA_WIDTH), is shared by all phases. It clears on every phase change.
- `smemaddr` and `smemwdata` are registers. They hold their last value until overwritten by the next frame.

## Timing
- Reset values:
  - state IDLE, so `sready` = 1;
  - `srdata`, `svalid`, `smemwen`, `smemren` = 0;
  - `smemaddr`, `smemwdata`, counter and shift register = 0.
- Reset asserted mid-frame aborts the frame immediately. No strobe is issued afterwards.
- `sready` falls in the cycle after the first address-bit edge.
- Write, gapless: address bits on edges E1..E12, data bits on E13..E20. `smemwen` is high in the cycle between E20 and E21. `sready` is high again after E21.
- Read, gapless: address bits on E1..E12. `smemren` is high between E12 and E13. The minimum memory latency is 1 cycle (`rvalid` sampled at E14 at the earliest).
- If `rvalid` is sampled at edge En, `svalid` is high from En to En+DATA_WIDTH, and `sready` returns at En+DATA_WIDTH.
- A new frame may begin on the first edge at which `sready` = 1. There is no dead cycle beyond that.

## Test plan
- Write: `smode` = 1, address 0x234, data 0xAA, gapless. Required: one `smemwen` pulse with `smemaddr` = 0x234 and `smemwdata` = 0xAA, 21 edges after the start; `svalid` stays 0 throughout.
- Read: address 0x234; memory returns 0x5C with `rvalid` 3 cycles after `smemren`. Required: a single `smemren` pulse with `smemaddr` = 0x234, then `srdata` = 0,0,1,1,1,0,1,0 (LSB first) over 8 `svalid` cycles.
- Gapped write: `mvalid` low for 2 cycles after bit 5 and for 3 cycles after data bit 3, address 0xFFF, data 0x81. Required: `smemwen` with 0xFFF / 0x81, delayed by exactly 5 cycles versus the gapless case.
- Back-to-back: write 0x001 ← 0x3C, then read 0x001 starting the edge `sready` rises, with a memory model. Required: the read returns 0x3C serially.
- Reset mid-read: deassert `rstn` during RDATA bit 3. Required: `svalid` = 0 and `sready` = 1 immediately, with no further strobes.
- Spurious inputs: `mvalid` toggled during RDATA, and `rvalid` pulsed while in IDLE. Required: no state change, the serial read output is unchanged, and no memory strobes occur.
